pc_jump_unit: RTL and testbench
===============================

// Module: pc_jump_unit
// PURPOSE
//  16-bit program counter with Hack-style jump resolution. It sits downstream of the
//  A-register input mux: the selected 16-bit value latched into A arrives here as
//  'target'. The ALU flags zr/ng plus the instruction's jump bits pick branch or PC+1.
//  Adds a boot cycle, halt/resume control and a saturating retired-instruction counter.
// PARAMETERS
//  WIDTH      16       PC/target/counter width in bits
//  RESET_VEC  16'h0000 PC value loaded on reset
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous reset, active low
//  en         in   1      advance PC this cycle (instruction retired)
//  is_c       in   1      current instruction is a C-instruction; jumps ignored when 0
//  jmp        in   3      jump bits {j1=lt, j2=eq, j3=gt}
//  zr         in   1      ALU result == 0
//  ng         in   1      ALU result < 0
//  target     in   WIDTH  jump destination (A register value)
//  halt_req   in   1      request halt; sampled only in RUN
//  resume     in   1      leave HALT; sampled only in HALT
//  pc         out  WIDTH  current program counter
//  pc_valid   out  1      pc is a fetchable address (RUN state)
//  taken      out  1      last advance was a taken jump (one-cycle pulse)
//  halted     out  1      state == HALT
//  instr_cnt  out  WIDTH  retired-instruction count, saturating
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_VEC, instr_cnt=0, taken=0, pc_valid=0, halted=0,
//   state=BOOT. Applies immediately from any state, mid-operation included.
//  FSM: BOOT -> RUN on first clk edge after reset release (unconditional).
//   RUN -> HALT when halt_req=1; HALT -> RUN when resume=1. No other transitions.
//  pc_valid = (state==RUN); halted = (state==HALT); both registered with state.
//  cond = is_c & ((jmp[2]&ng) | (jmp[1]&zr) | (jmp[0]&~ng&~zr)).
//   jmp=3'b000 never jumps; jmp=3'b111 always jumps (when is_c=1).
//  RUN, halt_req=0, en=1: cond ? pc<=target, taken<=1 : pc<=pc+1, taken<=0;
//   instr_cnt<=instr_cnt+1 unless already all-ones (saturates, no wrap).
//  RUN, halt_req=0, en=0: pc and instr_cnt hold; taken<=0.
//  RUN, halt_req=1: halt wins over en; no pc or counter update; taken<=0.
//  HALT/BOOT: pc, instr_cnt hold; en, is_c, jmp ignored; taken<=0.
//  Latency: one cycle from en edge to new pc/taken visible.
//  PC+1 wraps modulo 2^WIDTH (16'hFFFF -> 16'h0000); wrap is not an error.
//  zr and ng both 1 cannot happen from the ALU; the unit evaluates cond literally
//   and takes no other action.
//  resume and halt_req both high while in RUN: halt_req applies, resume ignored.
//   Both high while in HALT: resume applies, halt_req ignored.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  1 rst_n low 3 clk, release -> pc=0000, pc_valid=0 one clk, then pc_valid=1, halted=0.
//  2 en=1, is_c=0 for 4 clk -> pc 0001,0002,0003,0004; taken=0; instr_cnt=4.
//  3 is_c=1, jmp=001, zr=0, ng=0, target=0040, en=1 -> pc=0040, taken=1 for 1 clk;
//    then same with ng=1 -> pc=0041, taken=0.
//  4 pc forced to FFFF via jmp=111, target=FFFF; then en=1, is_c=0 -> pc=0000.
//  5 halt_req=1 with en=1 at pc=0010 -> halted=1, pc_valid=0, pc stays 0010;
//    resume=1 -> RUN, next en gives pc=0011.
//  6 rst_n pulsed low mid-jump (pc=0040) -> pc=0000 and instr_cnt=0 without clk edge;
//    BOOT cycle repeats.

Source files
------------

// File: rtl/pc_jump_unit.sv
// Program counter with Hack-style jump resolution, boot/run/halt control and a saturating retired count.
// Latency: one cycle from a retiring 'en' to the new pc/taken; every output is registered.
// Backpressure: none; halt_req stalls the PC, and en is ignored outside RUN.
module pc_jump_unit #(
    parameter int              WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             is_c,
    input  logic [2:0]       jmp,
    input  logic             zr,
    input  logic             ng,
    input  logic [WIDTH-1:0] target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             taken,
    output logic             halted,
    output logic [WIDTH-1:0] instr_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t state;
    logic   cond;

    // j1 = lt, j2 = eq, j3 = gt; a zr & ng combination is evaluated literally.
    assign cond = is_c & ((jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            instr_cnt <= '0;
            taken     <= 1'b0;
            pc_valid  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            taken <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= RUN;
                    pc_valid <= 1'b1;
                    halted   <= 1'b0;
                end
                RUN: begin
                    if (halt_req) begin
                        state    <= HALT;
                        pc_valid <= 1'b0;
                        halted   <= 1'b1;
                    end else if (en) begin
                        pc    <= cond ? target : pc + WIDTH'(1);
                        taken <= cond;
                        if (!(&instr_cnt))
                            instr_cnt <= instr_cnt + WIDTH'(1);
                    end
                end
                HALT: begin
                    if (resume) begin
                        state    <= RUN;
                        pc_valid <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                default: begin
                    state    <= BOOT;
                    pc_valid <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Directed and randomized bench for pc_jump_unit, checked against an abstract behavioural model.
module tb_pc_jump_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, is_c, zr, ng, halt_req, resume;
    logic [2:0]  jmp;
    logic [15:0] target;
    logic [15:0] pc, instr_cnt;
    logic        pc_valid, taken, halted;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    pc_jump_unit #(.WIDTH(16), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .is_c(is_c), .jmp(jmp), .zr(zr), .ng(ng),
        .target(target), .halt_req(halt_req), .resume(resume), .pc(pc),
        .pc_valid(pc_valid), .taken(taken), .halted(halted), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode  = 0;
    int unsigned m_pc    = 0;
    int unsigned m_cnt   = 0;
    bit          m_taken = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_taken = 0;
        end else begin
            bit lt, eq, gt, jump;
            m_taken = 0;
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 2) begin
                if (resume) m_mode = 1;
            end else if (halt_req) begin
                m_mode = 2;
            end else if (en) begin
                lt   = ng;
                eq   = zr;
                gt   = !ng && !zr;
                jump = is_c && ((jmp[2] && lt) || (jmp[1] && eq) || (jmp[0] && gt));
                m_pc    = jump ? int'(target) : (m_pc + 1) % 65536;
                m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_taken = jump;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pc",        32'(pc),        32'(m_pc));
            check("model_instr_cnt", 32'(instr_cnt), 32'(m_cnt));
            check("model_taken",     32'(taken),     32'(m_taken));
            check("model_pc_valid",  32'(pc_valid),  32'(m_mode == 1));
            check("model_halted",    32'(halted),    32'(m_mode == 2));
        end
    end

    task automatic cyc(input logic e, input logic c, input logic [2:0] j, input logic z,
                       input logic n, input logic [15:0] t, input logic h, input logic r);
        en = e; is_c = c; jmp = j; zr = z; ng = n; target = t; halt_req = h; resume = r;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 0; is_c = 0; jmp = 0; zr = 0; ng = 0; target = 0; halt_req = 0; resume = 0;
        repeat (3) @(negedge clk);
        check("rst_pc",        32'(pc),        32'h0000);
        check("rst_instr_cnt", 32'(instr_cnt), 32'h0000);
        check("rst_pc_valid",  32'(pc_valid),  32'h0);
        check("rst_halted",    32'(halted),    32'h0);
        check("rst_taken",     32'(taken),     32'h0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        #1 check("boot_pc_valid", 32'(pc_valid), 32'h0);
        @(negedge clk);
        check("run_pc_valid", 32'(pc_valid), 32'h1);
        check("run_halted",   32'(halted),   32'h0);

        for (int i = 1; i <= 4; i++) begin
            cyc(1, 0, 3'b000, 0, 0, 16'h0000, 0, 0);
            check("seq_pc", 32'(pc), 32'(i));
            check("seq_taken", 32'(taken), 32'h0);
        end
        check("seq_instr_cnt", 32'(instr_cnt), 32'd4);

        cyc(1, 1, 3'b001, 0, 0, 16'h0040, 0, 0);
        check("jgt_pc", 32'(pc), 32'h0040);
        check("jgt_taken", 32'(taken), 32'h1);
        cyc(1, 1, 3'b001, 0, 1, 16'h0040, 0, 0);
        check("jgt_ng_pc", 32'(pc), 32'h0041);
        check("jgt_ng_taken", 32'(taken), 32'h0);
        check("jgt_instr_cnt", 32'(instr_cnt), 32'd6);

        cyc(1, 1, 3'b111, 0, 0, 16'hFFFF, 0, 0);
        check("jmp_ffff_pc", 32'(pc), 32'hFFFF);
        cyc(1, 0, 3'b000, 0, 0, 16'h0000, 0, 0);
        check("wrap_pc", 32'(pc), 32'h0000);

        cyc(1, 1, 3'b111, 0, 0, 16'h0010, 0, 0);
        check("pre_halt_pc", 32'(pc), 32'h0010);
        cyc(1, 0, 3'b000, 0, 0, 16'h0000, 1, 0);
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_pc_valid", 32'(pc_valid), 32'h0);
        check("halt_pc", 32'(pc), 32'h0010);
        cyc(1, 1, 3'b111, 0, 0, 16'h1234, 1, 0);
        check("halt_hold_pc", 32'(pc), 32'h0010);
        cyc(0, 0, 3'b000, 0, 0, 16'h0000, 1, 1);
        check("resume_halted", 32'(halted), 32'h0);
        check("resume_pc_valid", 32'(pc_valid), 32'h1);
        cyc(1, 0, 3'b000, 0, 0, 16'h0000, 0, 0);
        check("resume_pc", 32'(pc), 32'h0011);

        cyc(1, 1, 3'b111, 0, 0, 16'h0040, 0, 0);
        check("pre_rst_pc", 32'(pc), 32'h0040);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pc", 32'(pc), 32'h0000);
        check("async_rst_instr_cnt", 32'(instr_cnt), 32'h0000);
        check("async_rst_pc_valid", 32'(pc_valid), 32'h0);
        cyc(0, 0, 3'b000, 0, 0, 16'h0000, 0, 0);
        rst_n = 1'b1;
        #1 check("reboot_pc_valid", 32'(pc_valid), 32'h0);
        @(negedge clk);
        check("rerun_pc_valid", 32'(pc_valid), 32'h1);

        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0); is_c = $urandom_range(0, 1);
            jmp = 3'($urandom); zr = ($urandom_range(0, 3) == 0); ng = $urandom_range(0, 1);
            target = 16'($urandom); halt_req = ($urandom_range(0, 11) == 0);
            resume = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        cyc(0, 0, 3'b000, 0, 0, 16'h0000, 0, 1);
        cyc(0, 0, 3'b000, 0, 0, 16'h0000, 0, 1);
        check("sat_pre_pc_valid", 32'(pc_valid), 32'h1);
        repeat (65540) cyc(1, 0, 3'b000, 0, 0, 16'h0000, 0, 0);
        check("sat_instr_cnt", 32'(instr_cnt), 32'hFFFF);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
